agc_io_arbiter: RTL and testbench
=================================

Name: agc_io_arbiter

Overview:
- Owns the AGC I/O channel register file: 32 channels, 15 bits each, selected by a 5-bit channel number.
- Shares the file between two requesters:
  - the Core, with priority and a single-cycle write path;
  - the host serial side, with valid/ready handshakes for DSKY verb/noun, mission time, apogee and perigee.
- Core writes to channels marked in TX_MASK are queued in an outbound FIFO for the serial transmitter.
- Replaces the hard-wired zero I/O input data at the top level.

Parameters:
- FIFO_DEPTH, 4: outbound notification FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 3: consecutive denied host-write cycles before the host is forced a grant.
- TX_MASK, 32'h0000_00F0: bit i=1 means Core writes to channel i are queued for transmit.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- IO_read_sel  in  5  Core read channel.
- IO_read_data  out  15  combinational read of channel IO_read_sel.
- IO_write_en  in  1  Core write request.
- IO_write_sel  in  5  Core write channel.
- IO_write_data  in  15  Core write data.
- core_hold  out  1  asks the Core to stall this cycle; ORed into the Core stall at the top level.
- host_wr_valid  in  1  host write request.
- host_wr_sel  in  5  host write channel.
- host_wr_data  in  15  host write data.
- host_wr_ready  out  1  host write accepted this cycle.
- host_rd_en  in  1  host read strobe.
- host_rd_sel  in  5  host read channel.
- host_rd_data  out  15  registered host read data.
- host_rd_valid  out  1  host_rd_data is valid this cycle.
- tx_valid  out  1  outbound FIFO not empty.
- tx_sel  out  5  channel of the head entry.
- tx_data  out  15  data of the head entry.
- tx_ready  in  1  transmitter pops the head entry.
- tx_overflow  out  1  sticky: a transmit entry was dropped.

Behaviour:
- Reset (synchronous, active-high):
  - all 32 channels clear to 0, FIFO empty, starvation counter 0;
  - outputs: core_hold=0, host_wr_ready=0, host_rd_valid=0, host_rd_data=0, tx_valid=0, tx_overflow=0;
  - a reset asserted mid-transfer discards the FIFO contents and any pending handshake.
- Single register-file write port; a write takes effect at the clock edge.
  - Core read is combinational and returns the pre-edge value, i.e. no bypass.
- Write arbitration, evaluated each cycle:
  - FORCE: starve_cnt==STARVE_LIMIT and host_wr_valid. Assert core_hold=1 and host_wr_ready=1; the host write commits; the Core write is ignored (the Core is stalled and re-presents it); starve_cnt resets to 0.
  - Otherwise, if IO_write_en, the Core write commits. If host_wr_valid, host_wr_ready=0 and starve_cnt increments, saturating at STARVE_LIMIT.
  - Otherwise, if host_wr_valid, the host write commits with host_wr_ready=1 and starve_cnt resets to 0.
  - Any cycle with host_wr_valid=0 resets starve_cnt to 0.
  - host_wr_ready is combinational from the current-cycle inputs and the counter.
- Host read:
  - host_rd_en samples the file at the edge;
  - host_rd_data and host_rd_valid are presented the next cycle (1-cycle latency), reflecting the pre-edge contents;
  - reads are always accepted.
- Outbound FIFO:
  - Push {IO_write_sel, IO_write_data} when a Core write commits and TX_MASK[IO_write_sel]=1. Writes not committed because of core_hold are not pushed.
  - Pop when tx_valid && tx_ready.
  - Push and pop in the same cycle is legal, including when full: the count is unchanged and the entry is accepted.
  - A push when full with no pop drops the entry and sets tx_overflow, which clears only on reset.
  - tx_sel/tx_data show the head entry with no extra latency.
  - Pointers wrap modulo FIFO_DEPTH.
- Host writes are never queued for transmit.
- All arithmetic is unsigned. The counter is $clog2(STARVE_LIMIT+1) bits; the FIFO count is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package agc_io_pkg holds:
  - CH_W=5, DATA_W=15, NUM_CH=32;
  - the channel index constants CH_DSKY_VERB, CH_DSKY_NOUN, CH_MISSION_TIME, CH_APOGEE, CH_PERIGEE;
  - typedef io_entry_t, a packed struct {sel, data}.
- One sub-module, io_tx_fifo: parameterised sync FIFO of io_entry_t providing full/empty/overflow.
- Arbitration and the register file stay in the top module.

Test Plan:
- Reset, then Core writes ch4=15'h1234 (TX_MASK bit set) -> same cycle IO_read_sel=4 reads 0. Next cycle it reads 15'h1234; tx_valid=1, tx_sel=4, tx_data=15'h1234.
- Host writes ch1=15'h0025 with no Core write -> host_wr_ready=1 that cycle. host_rd_en sel=1 on the next cycle -> host_rd_data=15'h0025, host_rd_valid=1 one cycle later.
- Host write held valid while the Core writes 4 consecutive cycles -> ready=0 for cycles 1-3. Cycle 4: core_hold=1, ready=1, host data committed, Core data not committed, starve_cnt=0.
- With tx_ready=0, perform 5 Core writes to ch4-7,4 -> FIFO holds 4 entries, the 5th is dropped, tx_overflow=1. Then tx_ready=1 -> entries pop in order 4,5,6,7.
- FIFO full, Core write to ch5 with tx_ready=1 in the same cycle -> head popped, new entry appended, count stays 4, tx_overflow unchanged.
- Assert reset mid-stream with FIFO non-empty -> next cycle tx_valid=0, all channels read 0, tx_overflow=0.

Source files
------------

// File: rtl/agc_io_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : agc_io_pkg
//  Brief    : Shared widths, channel numbers and the transmit entry type
//             used by the AGC I/O channel arbiter and its outbound FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package agc_io_pkg;

    localparam int CH_W   = 5;
    localparam int DATA_W = 15;
    localparam int NUM_CH = 32;

    // Channels the host serial side maintains
    localparam logic [CH_W-1:0] CH_DSKY_VERB    = 5'd1;
    localparam logic [CH_W-1:0] CH_DSKY_NOUN    = 5'd2;
    localparam logic [CH_W-1:0] CH_MISSION_TIME = 5'd3;
    localparam logic [CH_W-1:0] CH_APOGEE       = 5'd8;
    localparam logic [CH_W-1:0] CH_PERIGEE      = 5'd9;

    // One outbound notification: which channel the Core wrote and the value
    typedef struct packed {
        logic [CH_W-1:0]   sel;
        logic [DATA_W-1:0] data;
    } io_entry_t;

endpackage
`default_nettype wire

// File: rtl/io_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : io_tx_fifo
//  Brief    : Synchronous FIFO of io_entry_t with show-ahead head, full,
//             empty and a sticky overflow flag for dropped pushes.
//  Revision : 1.0 - initial release
// ============================================================================
module io_tx_fifo
    import agc_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  io_entry_t i_entry,
    input  logic      i_pop,
    output io_entry_t o_head,
    output logic      o_full,
    output logic      o_empty,
    output logic      o_overflow
);

    localparam int AW = $clog2(DEPTH);

    io_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_drop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // is still accepted when the head is leaving at the same edge.
    always_comb begin
        o_empty    = (r_count == '0);
        o_full     = (r_count == (AW+1)'(DEPTH));
        w_pop      = i_pop && !o_empty;
        w_push_ok  = i_push && (!o_full || w_pop);
        w_drop     = i_push && o_full && !w_pop;
        o_head     = r_mem[r_rd_ptr];
        o_overflow = r_overflow;
    end

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/agc_io_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : agc_io_arbiter
//  Brief    : AGC I/O channel register file shared between the Core
//             (priority, single-cycle write) and the host serial side
//             (valid/ready), with starvation relief for the host and an
//             outbound FIFO of Core writes to transmit-marked channels.
//  Revision : 1.0 - initial release
// ============================================================================
module agc_io_arbiter
    import agc_io_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          STARVE_LIMIT = 3,
    parameter logic [31:0] TX_MASK      = 32'h0000_00F0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CH_W-1:0]   IO_read_sel,
    output logic [DATA_W-1:0] IO_read_data,
    input  logic              IO_write_en,
    input  logic [CH_W-1:0]   IO_write_sel,
    input  logic [DATA_W-1:0] IO_write_data,
    output logic              core_hold,
    input  logic              host_wr_valid,
    input  logic [CH_W-1:0]   host_wr_sel,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_ready,
    input  logic              host_rd_en,
    input  logic [CH_W-1:0]   host_rd_sel,
    output logic [DATA_W-1:0] host_rd_data,
    output logic              host_rd_valid,
    output logic              tx_valid,
    output logic [CH_W-1:0]   tx_sel,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              tx_overflow
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_LIMIT);

    logic [DATA_W-1:0] r_regs [NUM_CH];
    logic [SW-1:0]     r_starve;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic              w_force;
    logic              w_core_commit;
    logic              w_host_commit;
    logic              w_we;
    logic [CH_W-1:0]   w_wsel;
    logic [DATA_W-1:0] w_wdata;
    logic [SW-1:0]     w_starve_nxt;
    logic              w_push;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    io_entry_t         w_push_entry;
    io_entry_t         w_head;

    // Write arbitration: Core wins unless the host has waited STARVE_LIMIT
    // cycles, in which case the Core is held and the host gets the port.
    always_comb begin
        w_force       = !reset && host_wr_valid && (r_starve == c_STARVE_MAX);
        w_core_commit = !reset && IO_write_en && !w_force;
        w_host_commit = !reset && host_wr_valid && (w_force || !IO_write_en);
        w_we          = w_core_commit || w_host_commit;
        w_wsel        = w_host_commit ? host_wr_sel  : IO_write_sel;
        w_wdata       = w_host_commit ? host_wr_data : IO_write_data;
        w_starve_nxt  = '0;
        if (host_wr_valid && !w_host_commit && (r_starve != c_STARVE_MAX)) begin
            w_starve_nxt = r_starve + SW'(1);
        end
        core_hold     = w_force;
        host_wr_ready = w_host_commit;
        IO_read_data  = r_regs[IO_read_sel];
        w_push        = w_core_commit && TX_MASK[IO_write_sel];
        w_push_entry  = '{sel: IO_write_sel, data: IO_write_data};
        tx_valid      = !w_fifo_empty;
        tx_sel        = w_head.sel;
        tx_data       = w_head.data;
        host_rd_data  = r_rd_data;
        host_rd_valid = r_rd_valid;
    end

    // Register file, starvation counter and registered host read port
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_regs[i] <= '0;
            end
            r_starve   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_we) begin
                r_regs[w_wsel] <= w_wdata;
            end
            r_starve   <= w_starve_nxt;
            r_rd_valid <= host_rd_en;
            if (host_rd_en) begin
                r_rd_data <= r_regs[host_rd_sel];
            end
        end
    end

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk        (clock),
        .rst        (reset),
        .i_push     (w_push),
        .i_entry    (w_push_entry),
        .i_pop      (tx_ready),
        .o_head     (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_overflow (tx_overflow)
    );

    // A full FIFO can never also report empty
    a_full_not_empty : assert property (@(posedge clock) disable iff (reset)
        !(w_fifo_full && w_fifo_empty));

endmodule
`default_nettype wire

// File: tb/tb_agc_io_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_agc_io_arbiter
//  Brief    : Directed self-checking bench for agc_io_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_agc_io_arbiter;

    logic        clock;
    logic        reset;
    logic [4:0]  IO_read_sel;
    logic [14:0] IO_read_data;
    logic        IO_write_en;
    logic [4:0]  IO_write_sel;
    logic [14:0] IO_write_data;
    logic        core_hold;
    logic        host_wr_valid;
    logic [4:0]  host_wr_sel;
    logic [14:0] host_wr_data;
    logic        host_wr_ready;
    logic        host_rd_en;
    logic [4:0]  host_rd_sel;
    logic [14:0] host_rd_data;
    logic        host_rd_valid;
    logic        tx_valid;
    logic [4:0]  tx_sel;
    logic [14:0] tx_data;
    logic        tx_ready;
    logic        tx_overflow;

    int n_checks;
    int n_fail;

    agc_io_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (3),
        .TX_MASK      (32'h0000_00F0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .IO_read_sel   (IO_read_sel),
        .IO_read_data  (IO_read_data),
        .IO_write_en   (IO_write_en),
        .IO_write_sel  (IO_write_sel),
        .IO_write_data (IO_write_data),
        .core_hold     (core_hold),
        .host_wr_valid (host_wr_valid),
        .host_wr_sel   (host_wr_sel),
        .host_wr_data  (host_wr_data),
        .host_wr_ready (host_wr_ready),
        .host_rd_en    (host_rd_en),
        .host_rd_sel   (host_rd_sel),
        .host_rd_data  (host_rd_data),
        .host_rd_valid (host_rd_valid),
        .tx_valid      (tx_valid),
        .tx_sel        (tx_sel),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .tx_overflow   (tx_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        IO_read_sel   = '0;
        IO_write_en   = 1'b0;
        IO_write_sel  = '0;
        IO_write_data = '0;
        host_wr_valid = 1'b0;
        host_wr_sel   = '0;
        host_wr_data  = '0;
        host_rd_en    = 1'b0;
        host_rd_sel   = '0;
        tx_ready      = 1'b0;
    endtask

    task automatic core_write(input logic [4:0] sel, input logic [14:0] data);
        IO_write_en   = 1'b1;
        IO_write_sel  = sel;
        IO_write_data = data;
        tick();
        IO_write_en   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL reset_core_hold got=%b exp=0", core_hold); end
        n_checks++; if (host_wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready got=%b exp=0", host_wr_ready); end
        n_checks++; if (host_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", host_rd_valid); end
        n_checks++; if (host_rd_data !== 15'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", host_rd_data); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_tx_overflow got=%b exp=0", tx_overflow); end
    endtask

    task automatic test_core_write();
        IO_read_sel   = 5'd4;
        IO_write_en   = 1'b1;
        IO_write_sel  = 5'd4;
        IO_write_data = 15'h1234;
        #1;
        n_checks++; if (IO_read_data !== 15'h0) begin n_fail++; $display("FAIL core_wr_no_bypass got=%h exp=0000", IO_read_data); end
        n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL core_wr_hold got=%b exp=0", core_hold); end
        tick();
        IO_write_en = 1'b0;
        #1;
        n_checks++; if (IO_read_data !== 15'h1234) begin n_fail++; $display("FAIL core_wr_readback got=%h exp=1234", IO_read_data); end
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL core_wr_tx_valid got=%b exp=1", tx_valid); end
        n_checks++; if (tx_sel !== 5'd4) begin n_fail++; $display("FAIL core_wr_tx_sel got=%0d exp=4", tx_sel); end
        n_checks++; if (tx_data !== 15'h1234) begin n_fail++; $display("FAIL core_wr_tx_data got=%h exp=1234", tx_data); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL core_wr_drain got=%b exp=0", tx_valid); end
    endtask

    task automatic test_host_write();
        host_wr_valid = 1'b1;
        host_wr_sel   = 5'd1;
        host_wr_data  = 15'h0025;
        #1;
        n_checks++; if (host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL host_wr_ready got=%b exp=1", host_wr_ready); end
        tick();
        host_wr_valid = 1'b0;
        host_rd_en    = 1'b1;
        host_rd_sel   = 5'd1;
        tick();
        host_rd_en    = 1'b0;
        #1;
        n_checks++; if (host_rd_valid !== 1'b1) begin n_fail++; $display("FAIL host_rd_valid got=%b exp=1", host_rd_valid); end
        n_checks++; if (host_rd_data !== 15'h0025) begin n_fail++; $display("FAIL host_rd_data got=%h exp=0025", host_rd_data); end
        tick();
        n_checks++; if (host_rd_valid !== 1'b0) begin n_fail++; $display("FAIL host_rd_valid_drop got=%b exp=0", host_rd_valid); end
        // Host write to a transmit-marked channel must not be queued
        host_wr_valid = 1'b1;
        host_wr_sel   = 5'd5;
        host_wr_data  = 15'h0777;
        tick();
        host_wr_valid = 1'b0;
        IO_read_sel   = 5'd5;
        #1;
        n_checks++; if (IO_read_data !== 15'h0777) begin n_fail++; $display("FAIL host_wr_ch5 got=%h exp=0777", IO_read_data); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL host_wr_not_queued got=%b exp=0", tx_valid); end
    endtask

    task automatic test_starvation();
        logic [14:0] core_vals [4];
        core_vals[0] = 15'h0111;
        core_vals[1] = 15'h0222;
        core_vals[2] = 15'h0333;
        core_vals[3] = 15'h0444;
        host_wr_valid = 1'b1;
        host_wr_sel   = 5'd2;
        host_wr_data  = 15'h0AAA;
        for (int k = 0; k < 4; k++) begin
            IO_write_en   = 1'b1;
            IO_write_sel  = 5'd3;
            IO_write_data = core_vals[k];
            #1;
            if (k < 3) begin
                n_checks++; if (host_wr_ready !== 1'b0) begin n_fail++; $display("FAIL starve_ready_c%0d got=%b exp=0", k + 1, host_wr_ready); end
                n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL starve_hold_c%0d got=%b exp=0", k + 1, core_hold); end
            end else begin
                n_checks++; if (host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL starve_force_ready got=%b exp=1", host_wr_ready); end
                n_checks++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL starve_force_hold got=%b exp=1", core_hold); end
            end
            tick();
        end
        // Counter cleared by the forced grant: next contended cycle is a denial
        host_wr_data  = 15'h0BBB;
        IO_write_data = 15'h0555;
        #1;
        n_checks++; if (host_wr_ready !== 1'b0) begin n_fail++; $display("FAIL starve_cnt_cleared got=%b exp=0", host_wr_ready); end
        n_checks++; if (core_hold !== 1'b0) begin n_fail++; $display("FAIL starve_after_hold got=%b exp=0", core_hold); end
        host_wr_valid = 1'b0;
        IO_write_en   = 1'b0;
        IO_read_sel   = 5'd2;
        #1;
        n_checks++; if (IO_read_data !== 15'h0AAA) begin n_fail++; $display("FAIL starve_host_data got=%h exp=0aaa", IO_read_data); end
        IO_read_sel = 5'd3;
        #1;
        n_checks++; if (IO_read_data !== 15'h0333) begin n_fail++; $display("FAIL starve_core_ignored got=%h exp=0333", IO_read_data); end
        tick();
    endtask

    task automatic drain_expect(input logic [4:0] s0, input logic [14:0] d0,
                                input logic [4:0] s1, input logic [14:0] d1,
                                input logic [4:0] s2, input logic [14:0] d2,
                                input logic [4:0] s3, input logic [14:0] d3);
        logic [4:0]  es [4];
        logic [14:0] ed [4];
        es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
        ed[0] = d0; ed[1] = d1; ed[2] = d2; ed[3] = d3;
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (tx_valid !== 1'b1 || tx_sel !== es[k] || tx_data !== ed[k]) begin
                n_fail++;
                $display("FAIL drain_entry%0d got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h",
                         k, tx_valid, tx_sel, tx_data, es[k], ed[k]);
            end
            tick();
        end
        tx_ready = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", tx_valid); end
    endtask

    task automatic fill_four();
        core_write(5'd4, 15'h0104);
        core_write(5'd5, 15'h0105);
        core_write(5'd6, 15'h0106);
        core_write(5'd7, 15'h0107);
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        fill_four();
        core_write(5'd4, 15'h0204);
        #1;
        n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", tx_overflow); end
        drain_expect(5'd4, 15'h0104, 5'd5, 15'h0105, 5'd6, 15'h0106, 5'd7, 15'h0107);
        n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", tx_overflow); end
    endtask

    task automatic test_full_push_pop();
        fill_four();
        IO_write_en   = 1'b1;
        IO_write_sel  = 5'd5;
        IO_write_data = 15'h0555;
        tx_ready      = 1'b1;
        #1;
        n_checks++; if (tx_sel !== 5'd4 || tx_data !== 15'h0104) begin n_fail++; $display("FAIL fullpp_head_before got sel=%0d data=%h exp sel=4 data=0104", tx_sel, tx_data); end
        tick();
        IO_write_en = 1'b0;
        tx_ready    = 1'b0;
        #1;
        n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL fullpp_ovf got=%b exp=1", tx_overflow); end
        drain_expect(5'd5, 15'h0105, 5'd6, 15'h0106, 5'd7, 15'h0107, 5'd5, 15'h0555);
    endtask

    task automatic test_reset_mid_stream();
        int bad;
        core_write(5'd6, 15'h0666);
        #1;
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got=%b exp=1", tx_valid); end
        host_rd_en  = 1'b1;
        host_rd_sel = 5'd6;
        tick();
        host_rd_en = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_valid got=%b exp=0", tx_valid); end
        n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got=%b exp=0", tx_overflow); end
        n_checks++; if (host_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_valid got=%b exp=0", host_rd_valid); end
        bad = 0;
        for (int c = 0; c < 32; c++) begin
            IO_read_sel = 5'(c);
            #1;
            if (IO_read_data !== 15'h0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_channels got=%0d nonzero exp=0", bad); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_core_write();
        test_host_write();
        test_starvation();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
